// File: rtl/ysyx_24100006_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU memory arbiter.
// The "slave" view is the arbiter itself: it answers the IFU/LSU requests and drives
// the memory request. The "master" view is the surrounding system, with IFU, LSU and
// memory seen from outside the arbiter.
interface ysyx_24100006_mem_arbiter_if;
    // IFU side
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_flush;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    // LSU side
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    // Memory side
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_flush, ifu_resp_ready,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb, lsu_resp_ready,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_flush, ifu_resp_ready,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb, lsu_resp_ready,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_24100006_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, one transaction outstanding.
// LSU has priority; after MAX_LS_STREAK consecutive LSU grants with the IFU waiting,
// the IFU is forced a grant. An IFU flush turns an in-flight fetch into a silent drop.
// Optional macro ARB_PERF_CNT_EN adds grant and conflict performance counters.
module ysyx_24100006_mem_arbiter #(
    parameter int unsigned MAX_LS_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    ysyx_24100006_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_ifu_grants,
    output logic [31:0] perf_lsu_grants,
    output logic [31:0] perf_conflict_cycles
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        drop_q, drop_d;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic in_idle, in_req, in_resp;
    logic lsu_win, grant_lsu, grant_ifu;
    logic owner_is_ifu, drop_now, owner_resp_ready, resp_hs;

    // Outputs are forced quiet while reset is held, even before the clock edge.
    assign in_idle = reset && (state_q == S_IDLE);
    assign in_req  = reset && (state_q == S_REQ);
    assign in_resp = reset && (state_q == S_RESP);

    assign lsu_win   = bus.lsu_req_valid && !(bus.ifu_req_valid && (streak_q == STREAK_MAX));
    assign grant_lsu = in_idle && lsu_win;
    assign grant_ifu = in_idle && !lsu_win && bus.ifu_req_valid && !bus.ifu_flush;

    // A flush landing in the handshake cycle must already hide that response.
    assign owner_is_ifu     = (owner_q == OWN_IFU);
    assign drop_now         = owner_is_ifu && (drop_q || bus.ifu_flush);
    assign owner_resp_ready = owner_is_ifu ? bus.ifu_resp_ready : bus.lsu_resp_ready;
    assign resp_hs          = in_resp && bus.mem_resp_valid && bus.mem_resp_ready;

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.mem_req_valid  = in_req;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wstrb      = wstrb_q;
    assign bus.mem_resp_ready = in_resp && (drop_now || owner_resp_ready);
    assign bus.ifu_resp_valid = in_resp && owner_is_ifu && !drop_now && bus.mem_resp_valid;
    assign bus.ifu_rdata      = bus.mem_rdata;
    assign bus.ifu_resp_err   = in_resp && owner_is_ifu && !drop_now && bus.mem_resp_err;
    assign bus.lsu_resp_valid = in_resp && !owner_is_ifu && bus.mem_resp_valid;
    assign bus.lsu_rdata      = bus.mem_rdata;
    assign bus.lsu_resp_err   = in_resp && !owner_is_ifu && bus.mem_resp_err;

    // Next-state logic: grant and latch in IDLE, wait for request and response handshakes.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (grant_ifu || !bus.ifu_req_valid) begin
                    streak_d = 4'd0;
                end else if (grant_lsu && (streak_q < STREAK_MAX)) begin
                    streak_d = streak_q + 4'd1;
                end
                if (grant_lsu) begin
                    state_d = S_REQ;
                    owner_d = OWN_LSU;
                    addr_d  = bus.lsu_addr;
                    wen_d   = bus.lsu_wen;
                    wdata_d = bus.lsu_wdata;
                    wstrb_d = bus.lsu_wstrb;
                end else if (grant_ifu) begin
                    state_d = S_REQ;
                    owner_d = OWN_IFU;
                    addr_d  = bus.ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = 32'd0;
                    wstrb_d = 4'b0000;
                end
            end
            S_REQ: begin
                if (owner_is_ifu && bus.ifu_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_hs) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                end else if (owner_is_ifu && bus.ifu_flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // State and latched request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_IFU;
            drop_q   <= 1'b0;
            streak_q <= 4'd0;
            addr_q   <= 32'd0;
            wen_q    <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_ifu_q, perf_lsu_q, perf_conf_q;

    // Free-running wrap-around counters of grants and contended IDLE cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_ifu_q  <= 32'd0;
            perf_lsu_q  <= 32'd0;
            perf_conf_q <= 32'd0;
        end else begin
            if (grant_ifu) perf_ifu_q <= perf_ifu_q + 32'd1;
            if (grant_lsu) perf_lsu_q <= perf_lsu_q + 32'd1;
            if (in_idle && bus.ifu_req_valid && bus.lsu_req_valid) perf_conf_q <= perf_conf_q + 32'd1;
        end
    end

    assign perf_ifu_grants      = perf_ifu_q;
    assign perf_lsu_grants      = perf_lsu_q;
    assign perf_conflict_cycles = perf_conf_q;
`endif
endmodule

// File: tb/tb_ysyx_24100006_mem_arbiter.sv
// Self-checking bench for ysyx_24100006_mem_arbiter: expected responses go into a
// scoreboard queue when a request is granted and are popped when the owner's response
// appears. Build with ARB_PERF_CNT_EN to also check the performance counters.
module tb_ysyx_24100006_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ysyx_24100006_mem_arbiter_if bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_ifu_grants, perf_lsu_grants, perf_conflict_cycles;
`endif

    ysyx_24100006_mem_arbiter #(.MAX_LS_STREAK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_ifu_grants      (perf_ifu_grants),
        .perf_lsu_grants      (perf_lsu_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    typedef struct {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic sb_push(input logic lsu, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.lsu   = lsu;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_own_valid"},   e.lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid, 32'd1);
            check({tag, "_other_valid"}, e.lsu ? bus.ifu_resp_valid : bus.lsu_resp_valid, 32'd0);
            check({tag, "_rdata"},       e.lsu ? bus.lsu_rdata : bus.ifu_rdata, e.rdata);
            check({tag, "_err"},         e.lsu ? bus.lsu_resp_err : bus.ifu_resp_err, 32'(e.err));
        end
    endtask

    task automatic idle_inputs();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = 32'd0;
        bus.ifu_flush      = 1'b0;
        bus.ifu_resp_ready = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = 32'd0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = 32'd0;
        bus.lsu_wstrb      = 4'd0;
        bus.lsu_resp_ready = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;
        bus.mem_resp_err   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   m_streak;
        logic exp_lsu;

        // Reset with both requesters active: nothing may be granted.
        reset = 1'b0;
        idle_inputs();
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        repeat (3) step();
        mid();
        check("rst_ifu_req_ready",  bus.ifu_req_ready, 0);
        check("rst_lsu_req_ready",  bus.lsu_req_ready, 0);
        check("rst_mem_req_valid",  bus.mem_req_valid, 0);
        check("rst_mem_resp_ready", bus.mem_resp_ready, 0);
        check("rst_ifu_resp_valid", bus.ifu_resp_valid, 0);
        check("rst_lsu_resp_valid", bus.lsu_resp_valid, 0);
        check("rst_mem_addr",       bus.mem_addr, 0);
        check("rst_mem_wdata",      bus.mem_wdata, 0);
        check("rst_mem_wstrb",      bus.mem_wstrb, 0);
        check("rst_mem_wen",        bus.mem_wen, 0);
`ifdef ARB_PERF_CNT_EN
        check("rst_perf_conf", perf_conflict_cycles, 0);
`endif
        step();
        reset = 1'b1;
        idle_inputs();
        step();

        // Single IFU fetch.
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 32'h3000_0000;
        bus.ifu_resp_ready = 1'b1;
        bus.mem_req_ready  = 1'b1;
        mid();
        check("t1_ifu_req_ready", bus.ifu_req_ready, 1);
        check("t1_lsu_req_ready", bus.lsu_req_ready, 0);
        check("t1_mem_req_valid0", bus.mem_req_valid, 0);
        sb_push(1'b0, 32'h0000_0413, 1'b0);
        step();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = 32'h0;
        mid();
        check("t1_mem_req_valid", bus.mem_req_valid, 1);
        check("t1_mem_addr",      bus.mem_addr, 32'h3000_0000);
        check("t1_mem_wstrb",     bus.mem_wstrb, 0);
        check("t1_mem_wen",       bus.mem_wen, 0);
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0413;
        mid();
        sb_pop_check("t1");
        check("t1_mem_req_valid_drop", bus.mem_req_valid, 0);
        check("t1_mem_resp_ready",     bus.mem_resp_ready, 1);
        step();
        idle_inputs();
        mid();
        check("t1_done_resp_valid", bus.ifu_resp_valid, 0);

        // LSU store held in REQ by memory backpressure.
        step();
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = 32'h8000_0010;
        bus.lsu_wen        = 1'b1;
        bus.lsu_wdata      = 32'hDEAD_BEEF;
        bus.lsu_wstrb      = 4'b0011;
        bus.lsu_resp_ready = 1'b1;
        mid();
        check("t2_lsu_req_ready", bus.lsu_req_ready, 1);
        check("t2_ifu_req_ready", bus.ifu_req_ready, 0);
        step();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = 32'h0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = 32'h0;
        bus.lsu_wstrb     = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            mid();
            check($sformatf("t2_hold%0d_valid", i), bus.mem_req_valid, 1);
            check($sformatf("t2_hold%0d_wen", i),   bus.mem_wen, 1);
            check($sformatf("t2_hold%0d_wstrb", i), bus.mem_wstrb, 32'h3);
            check($sformatf("t2_hold%0d_wdata", i), bus.mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("t2_hold%0d_addr", i),  bus.mem_addr, 32'h8000_0010);
            step();
        end
        bus.mem_req_ready = 1'b1;
        mid();
        check("t2_req_valid_hs", bus.mem_req_valid, 1);
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0;
        sb_push(1'b1, 32'h0, 1'b0);
        mid();
        sb_pop_check("t2");
        check("t2_mem_req_valid_drop", bus.mem_req_valid, 0);
        step();
        idle_inputs();

        // Both masters requesting continuously: LSU priority with IFU anti-starvation.
        bus.ifu_req_valid  = 1'b1;
        bus.lsu_req_valid  = 1'b1;
        bus.ifu_addr       = 32'h0000_1000;
        bus.lsu_addr       = 32'h0000_2000;
        bus.ifu_resp_ready = 1'b1;
        bus.lsu_resp_ready = 1'b1;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1111_0000;
        m_streak = 0;
        for (int t = 0; t < 6; t++) begin
            mid();
            exp_lsu = (m_streak != 4);
            check($sformatf("t3_g%0d_lsu_ready", t), bus.lsu_req_ready, 32'(exp_lsu));
            check($sformatf("t3_g%0d_ifu_ready", t), bus.ifu_req_ready, 32'(!exp_lsu));
            if (exp_lsu) m_streak = (m_streak < 4) ? m_streak + 1 : 4;
            else         m_streak = 0;
            sb_push(exp_lsu, 32'h1111_0000, 1'b0);
            step();
            mid();
            check($sformatf("t3_g%0d_mem_addr", t), bus.mem_addr, exp_lsu ? 32'h2000 : 32'h1000);
            step();
            mid();
            sb_pop_check($sformatf("t3_g%0d", t));
            step();
        end
        idle_inputs();

        // Flush in the first RESP cycle of an IFU fetch; response arrives two cycles later.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h3000_0004;
        bus.mem_req_ready = 1'b1;
        mid();
        check("t4_ifu_req_ready", bus.ifu_req_ready, 1);
        step();
        bus.ifu_req_valid = 1'b0;
        mid();
        check("t4_mem_req_valid", bus.mem_req_valid, 1);
        step();
        bus.mem_req_ready  = 1'b0;
        bus.ifu_flush      = 1'b1;
        bus.ifu_resp_ready = 1'b1;
        mid();
        check("t4_c0_resp_valid", bus.ifu_resp_valid, 0);
        check("t4_c0_resp_ready", bus.mem_resp_ready, 1);
        step();
        bus.ifu_flush = 1'b0;
        mid();
        check("t4_c1_resp_valid", bus.ifu_resp_valid, 0);
        check("t4_c1_resp_ready", bus.mem_resp_ready, 1);
        step();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0BAD;
        bus.ifu_resp_ready = 1'b0;
        mid();
        check("t4_c2_resp_valid", bus.ifu_resp_valid, 0);
        check("t4_c2_resp_ready", bus.mem_resp_ready, 1);
        step();
        idle_inputs();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_0020;
        mid();
        check("t4_next_lsu_ready", bus.lsu_req_ready, 1);

        // LSU load with error response and response backpressure.
        step();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        mid();
        check("t5_mem_req_valid", bus.mem_req_valid, 1);
        check("t5_mem_wen",       bus.mem_wen, 0);
        check("t5_mem_addr",      bus.mem_addr, 32'h8000_0020);
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_err   = 1'b1;
        bus.mem_rdata      = 32'hCAFE_0001;
        bus.lsu_resp_ready = 1'b0;
        sb_push(1'b1, 32'hCAFE_0001, 1'b1);
        for (int i = 0; i < 2; i++) begin
            mid();
            check($sformatf("t5_bp%0d_valid", i),      bus.lsu_resp_valid, 1);
            check($sformatf("t5_bp%0d_err", i),        bus.lsu_resp_err, 1);
            check($sformatf("t5_bp%0d_resp_ready", i), bus.mem_resp_ready, 0);
            step();
        end
        bus.lsu_resp_ready = 1'b1;
        mid();
        check("t5_resp_ready", bus.mem_resp_ready, 1);
        sb_pop_check("t5");
        step();
        idle_inputs();
        mid();
        check("t5_after_valid",      bus.lsu_resp_valid, 0);
        check("t5_after_resp_ready", bus.mem_resp_ready, 0);

        // Reset asserted while a fetch waits in REQ.
        step();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h3000_0008;
        mid();
        check("t6_ifu_req_ready", bus.ifu_req_ready, 1);
        step();
        mid();
        check("t6_mem_req_valid", bus.mem_req_valid, 1);
`ifdef ARB_PERF_CNT_EN
        check("t6_perf_ifu",  perf_ifu_grants, 4);
        check("t6_perf_lsu",  perf_lsu_grants, 7);
        check("t6_perf_conf", perf_conflict_cycles, 6);
`endif
        step();
        reset = 1'b0;
        step();
        mid();
        check("t6_rst_req_valid", bus.mem_req_valid, 0);
        check("t6_rst_mem_addr",  bus.mem_addr, 0);
        check("t6_rst_ifu_ready", bus.ifu_req_ready, 0);
`ifdef ARB_PERF_CNT_EN
        check("t6_rst_perf_ifu",  perf_ifu_grants, 0);
        check("t6_rst_perf_lsu",  perf_lsu_grants, 0);
        check("t6_rst_perf_conf", perf_conflict_cycles, 0);
`endif
        step();
        reset = 1'b1;
        mid();
        check("t6_idle_ifu_ready", bus.ifu_req_ready, 1);
        step();
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
